// File: rtl/divide_sequencer.sv
// divide_sequencer: time-shares one iterative divider across a batch of SIZE dividends.
// Optional feature macro DIV_ZERO_BYPASS_EN: zero divisors skip the divider and flag the element.
module divide_sequencer #(
    parameter int SIZE    = 6,
    parameter int WIDTH   = 14,
    parameter int MAX_LAT = 32
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          pause,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SIZE-1:0][WIDTH-1:0]    dividend_in,
    input  logic [SIZE/2-1:0][WIDTH-1:0]  divisor_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SIZE-1:0][WIDTH-1:0]    quotient_out,
    output logic [SIZE-1:0]               zero_flags,
    output logic [SIZE-1:0]               timeout_flags,
    output logic [WIDTH-1:0]              div_dividend_out,
    output logic [WIDTH-1:0]              div_divisor_out,
    output logic                          div_valid_out,
    output logic                          div_pause_out,
    input  logic [WIDTH-1:0]              div_quotient_in,
    input  logic                          div_valid_in,
    output logic [1:0]                    dbg_state
);

    localparam int IDX_W     = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int DIV_IDX_W = (SIZE > 2) ? $clog2(SIZE / 2) : 1;
    localparam int CNT_W     = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                        state;
    logic [IDX_W-1:0]              idx;
    logic [CNT_W-1:0]              cnt;
    logic [SIZE-1:0][WIDTH-1:0]    dividend_q;
    logic [SIZE/2-1:0][WIDTH-1:0]  divisor_q;
    logic [DIV_IDX_W-1:0]          div_idx;
    logic                          last_elem;
    logic                          bypass;

    // Handshakes: a batch transfers on a rising clk_in edge where in_valid && in_ready;
    // results transfer where out_valid && out_ready && !pause. in_ready is withheld while
    // paused; out_valid stays high through a pause but the transfer waits for it to drop.
    assign in_ready      = (state == IDLE) && !pause;
    assign out_valid     = (state == DONE);
    assign div_pause_out = pause;
    assign dbg_state     = state;

    assign div_idx          = DIV_IDX_W'(idx >> 1);
    assign last_elem        = (idx == IDX_W'(SIZE - 1));
    assign div_dividend_out = dividend_q[idx];
    assign div_divisor_out  = divisor_q[div_idx];

`ifdef DIV_ZERO_BYPASS_EN
    assign bypass = (divisor_q[div_idx] == '0);
`else
    assign bypass     = 1'b0;
    assign zero_flags = '0;
`endif

    assign div_valid_out = (state == ISSUE) && !pause && !bypass;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            idx           <= '0;
            cnt           <= '0;
            dividend_q    <= '0;
            divisor_q     <= '0;
            quotient_out  <= '0;
            timeout_flags <= '0;
`ifdef DIV_ZERO_BYPASS_EN
            zero_flags    <= '0;
`endif
        end else if (!pause) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dividend_q    <= dividend_in;
                        divisor_q     <= divisor_in;
                        timeout_flags <= '0;
`ifdef DIV_ZERO_BYPASS_EN
                        zero_flags    <= '0;
`endif
                        idx           <= '0;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                    if (bypass) begin
                        quotient_out[idx] <= '1;
`ifdef DIV_ZERO_BYPASS_EN
                        zero_flags[idx]   <= 1'b1;
`endif
                        if (last_elem) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ISSUE;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // A response arriving on the expiry cycle takes priority over the timeout.
                    if (div_valid_in || (cnt == CNT_W'(MAX_LAT - 1))) begin
                        if (div_valid_in) begin
                            quotient_out[idx] <= div_quotient_in;
                        end else begin
                            quotient_out[idx]  <= '1;
                            timeout_flags[idx] <= 1'b1;
                        end
                        if (last_elem) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divide_sequencer.sv
// tb_divide_sequencer: scoreboard bench for divide_sequencer with a fixed-latency divider model.
// Expectations follow DIV_ZERO_BYPASS_EN when it is defined for the build.
module tb_divide_sequencer;

    localparam int SIZE    = 6;
    localparam int WIDTH   = 14;
    localparam int MAX_LAT = 32;
    localparam int L       = 16;

    logic                          clk_in;
    logic                          rst_in;
    logic                          pause;
    logic                          in_valid;
    logic                          in_ready;
    logic [SIZE-1:0][WIDTH-1:0]    dividend_in;
    logic [SIZE/2-1:0][WIDTH-1:0]  divisor_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [SIZE-1:0][WIDTH-1:0]    quotient_out;
    logic [SIZE-1:0]               zero_flags;
    logic [SIZE-1:0]               timeout_flags;
    logic [WIDTH-1:0]              div_dividend_out;
    logic [WIDTH-1:0]              div_divisor_out;
    logic                          div_valid_out;
    logic                          div_pause_out;
    logic [WIDTH-1:0]              div_quotient_in;
    logic                          div_valid_in;
    logic [1:0]                    dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q[$];

    divide_sequencer #(.SIZE(SIZE), .WIDTH(WIDTH), .MAX_LAT(MAX_LAT)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .pause            (pause),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .dividend_in      (dividend_in),
        .divisor_in       (divisor_in),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .quotient_out     (quotient_out),
        .zero_flags       (zero_flags),
        .timeout_flags    (timeout_flags),
        .div_dividend_out (div_dividend_out),
        .div_divisor_out  (div_divisor_out),
        .div_valid_out    (div_valid_out),
        .div_pause_out    (div_pause_out),
        .div_quotient_in  (div_quotient_in),
        .div_valid_in     (div_valid_in),
        .dbg_state        (dbg_state)
    );

    // Clock and watchdog
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Divider model: answers L unpaused cycles after a strobe; may drop one chosen strobe.
    int               strobe_cnt     = 0;
    int               paused_strobes = 0;
    int               drop_strobe    = -1;
    int               rem            = 0;
    bit               pending        = 1'b0;
    bit               pend_drop      = 1'b0;
    logic [WIDTH-1:0] pend_q         = '0;

    initial begin
        div_valid_in    = 1'b0;
        div_quotient_in = '0;
    end

    always @(negedge clk_in) begin
        div_valid_in = 1'b0;
        if (pending && !pause) begin
            rem = rem - 1;
            if (rem == 0) begin
                pending = 1'b0;
                if (!pend_drop) begin
                    div_valid_in    = 1'b1;
                    div_quotient_in = pend_q;
                end
            end
        end
        if (div_valid_out === 1'b1) begin
            strobe_cnt = strobe_cnt + 1;
            if (pause) paused_strobes = paused_strobes + 1;
            pending   = 1'b1;
            rem       = L;
            pend_drop = (strobe_cnt == drop_strobe);
            pend_q    = (div_divisor_out == '0) ? '1 : div_dividend_out / div_divisor_out;
        end
    end

    // Driver: offers one batch, pushes expected quotients, runs until out_valid (bounded).
    task automatic drive_batch(input logic [SIZE-1:0][WIDTH-1:0] dv,
                               input logic [SIZE/2-1:0][WIDTH-1:0] ds,
                               input int drop_elem,
                               input int pa_lo, input int pa_hi,
                               input int pb_lo, input int pb_hi,
                               output int done_cyc, output int strobes, output int bad_strobes);
        int s0;
        int p0;
        logic [WIDTH-1:0] e;
        for (int i = 0; i < SIZE; i++) begin
            if (i == drop_elem || ds[i/2] == '0) e = '1;
            else e = WIDTH'(dv[i] / ds[i/2]);
            exp_q.push_back(e);
        end
        s0 = strobe_cnt;
        p0 = paused_strobes;
        drop_strobe = (drop_elem >= 0) ? s0 + drop_elem + 1 : -1;
        @(posedge clk_in); #1;
        dividend_in = dv;
        divisor_in  = ds;
        in_valid    = 1'b1;
        @(posedge clk_in); #1;
        in_valid = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
            pause = (c >= pa_lo && c <= pa_hi) || (c >= pb_lo && c <= pb_hi);
            @(negedge clk_in);
            if (out_valid === 1'b1) done_cyc = c;
            else begin
                @(posedge clk_in); #1;
            end
        end
        pause       = 1'b0;
        strobes     = strobe_cnt - s0;
        bad_strobes = paused_strobes - p0;
        drop_strobe = -1;
    endtask

    task automatic finish_batch();
        out_ready = 1'b1;
        @(posedge clk_in); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (div_valid_out !== 1'b0) begin failures++; $display("FAIL reset_div_valid got=%b exp=0", div_valid_out); end
        checks++; if (quotient_out !== '0) begin failures++; $display("FAIL reset_quotients got=%h exp=0", quotient_out); end
        checks++; if (zero_flags !== '0) begin failures++; $display("FAIL reset_zero_flags got=%b exp=0", zero_flags); end
        checks++; if (timeout_flags !== '0) begin failures++; $display("FAIL reset_timeout_flags got=%b exp=0", timeout_flags); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    endtask

    task automatic test_normal();
        int done_cyc, strobes, bad;
        logic [WIDTH-1:0] e;
        drive_batch({14'd600, 14'd500, 14'd400, 14'd300, 14'd200, 14'd100},
                    {14'd30, 14'd20, 14'd10}, -1, -1, -1, -1, -1, done_cyc, strobes, bad);
        checks++; if (done_cyc !== 103) begin failures++; $display("FAIL normal_done_cycle got=%0d exp=103", done_cyc); end
        checks++; if (strobes !== 6) begin failures++; $display("FAIL normal_strobes got=%0d exp=6", strobes); end
        checks++; if ({zero_flags, timeout_flags} !== '0) begin failures++; $display("FAIL normal_flags got=%b/%b exp=0/0", zero_flags, timeout_flags); end
        for (int i = 0; i < SIZE; i++) begin
            e = exp_q.pop_front();
            checks++; if (quotient_out[i] !== e) begin failures++; $display("FAIL normal_q%0d got=%h exp=%h", i, quotient_out[i], e); end
        end
        finish_batch();
    endtask

    task automatic test_zero_divisor();
        int done_cyc, strobes, bad;
        int exp_done, exp_strobes;
        logic [SIZE-1:0] exp_zero;
        logic [WIDTH-1:0] e;
`ifdef DIV_ZERO_BYPASS_EN
        exp_done = 71; exp_strobes = 4; exp_zero = 6'b001100;
`else
        exp_done = 103; exp_strobes = 6; exp_zero = 6'b000000;
`endif
        drive_batch({SIZE{14'd35}}, {14'd7, 14'd0, 14'd5}, -1, -1, -1, -1, -1,
                    done_cyc, strobes, bad);
        checks++; if (done_cyc !== exp_done) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=%0d", done_cyc, exp_done); end
        checks++; if (strobes !== exp_strobes) begin failures++; $display("FAIL zero_strobes got=%0d exp=%0d", strobes, exp_strobes); end
        checks++; if (zero_flags !== exp_zero) begin failures++; $display("FAIL zero_flags got=%b exp=%b", zero_flags, exp_zero); end
        for (int i = 0; i < SIZE; i++) begin
            e = exp_q.pop_front();
            checks++; if (quotient_out[i] !== e) begin failures++; $display("FAIL zero_q%0d got=%h exp=%h", i, quotient_out[i], e); end
        end
        finish_batch();
    endtask

    task automatic test_timeout();
        int done_cyc, strobes, bad;
        logic [WIDTH-1:0] e;
        drive_batch({14'd600, 14'd500, 14'd400, 14'd300, 14'd200, 14'd100},
                    {14'd30, 14'd20, 14'd10}, 1, -1, -1, -1, -1, done_cyc, strobes, bad);
        checks++; if (done_cyc !== 103 + MAX_LAT - L) begin failures++; $display("FAIL timeout_done_cycle got=%0d exp=%0d", done_cyc, 103 + MAX_LAT - L); end
        checks++; if (timeout_flags !== 6'b000010) begin failures++; $display("FAIL timeout_flags got=%b exp=000010", timeout_flags); end
        for (int i = 0; i < SIZE; i++) begin
            e = exp_q.pop_front();
            checks++; if (quotient_out[i] !== e) begin failures++; $display("FAIL timeout_q%0d got=%h exp=%h", i, quotient_out[i], e); end
        end
        finish_batch();
    endtask

    task automatic test_pause();
        int done_cyc, strobes, bad;
        logic [WIDTH-1:0] e;
        // Cycles 40-49 fall in element 2's WAIT, cycles 79-81 in element 4's ISSUE.
        drive_batch({14'd600, 14'd500, 14'd400, 14'd300, 14'd200, 14'd100},
                    {14'd30, 14'd20, 14'd10}, -1, 40, 49, 79, 81, done_cyc, strobes, bad);
        checks++; if (done_cyc !== 116) begin failures++; $display("FAIL pause_done_cycle got=%0d exp=116", done_cyc); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL pause_strobe_while_paused got=%0d exp=0", bad); end
        checks++; if (strobes !== 6) begin failures++; $display("FAIL pause_strobes got=%0d exp=6", strobes); end
        for (int i = 0; i < SIZE; i++) begin
            e = exp_q.pop_front();
            checks++; if (quotient_out[i] !== e) begin failures++; $display("FAIL pause_q%0d got=%h exp=%h", i, quotient_out[i], e); end
        end
        pause = 1'b1;
        #1;
        checks++; if (div_pause_out !== 1'b1) begin failures++; $display("FAIL pause_forward got=%b exp=1", div_pause_out); end
        pause = 1'b0;
        #1;
        checks++; if (div_pause_out !== 1'b0) begin failures++; $display("FAIL pause_release got=%b exp=0", div_pause_out); end
        finish_batch();
    endtask

    task automatic test_backpressure();
        int done_cyc, strobes, bad;
        logic [SIZE-1:0][WIDTH-1:0]   dv;
        logic [SIZE/2-1:0][WIDTH-1:0] ds;
        logic [SIZE-1:0][WIDTH-1:0]   exp_vec;
        for (int i = 0; i < SIZE; i++) dv[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        for (int i = 0; i < SIZE/2; i++) ds[i] = WIDTH'($urandom_range(1, 300));
        drive_batch(dv, ds, -1, -1, -1, -1, -1, done_cyc, strobes, bad);
        checks++; if (done_cyc !== 103) begin failures++; $display("FAIL bp_done_cycle got=%0d exp=103", done_cyc); end
        for (int i = 0; i < SIZE; i++) exp_vec[i] = exp_q.pop_front();
        checks++; if (quotient_out !== exp_vec) begin failures++; $display("FAIL bp_quotients got=%h exp=%h", quotient_out, exp_vec); end
        @(posedge clk_in); #1;
        in_valid    = 1'b1;
        dividend_in = {SIZE{14'h1234}};
        divisor_in  = {(SIZE/2){14'd3}};
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_in);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient_out !== exp_vec) begin
                failures++;
                $display("FAIL bp_hold_c%0d got=v%b r%b q=%h exp=v1 r0 q=%h", c, out_valid, in_ready, quotient_out, exp_vec);
            end
            @(posedge clk_in); #1;
        end
        in_valid = 1'b0;
        finish_batch();
        @(negedge clk_in);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
        checks++; if (quotient_out !== exp_vec) begin failures++; $display("FAIL bp_persist got=%h exp=%h", quotient_out, exp_vec); end
    endtask

    task automatic test_reset_mid_wait();
        @(posedge clk_in); #1;
        dividend_in = {SIZE{14'd77}};
        divisor_in  = {(SIZE/2){14'd7}};
        in_valid    = 1'b1;
        @(posedge clk_in); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk_in); #1;
        end
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", dbg_state); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        checks++; if (quotient_out !== '0) begin failures++; $display("FAIL rstmid_quotients got=%h exp=0", quotient_out); end
        // The model's response for element 0 lands around cycle 17, well inside this window.
        repeat (20) @(negedge clk_in);
        checks++; if (dbg_state !== 2'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_late_pulse state=%0d ready=%b exp=0/1", dbg_state, in_ready); end
        checks++; if (quotient_out !== '0) begin failures++; $display("FAIL rstmid_late_quotients got=%h exp=0", quotient_out); end
    endtask

    initial begin
        rst_in      = 1'b1;
        pause       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        dividend_in = '0;
        divisor_in  = '0;
        test_reset();
        test_normal();
        test_zero_divisor();
        test_timeout();
        test_pause();
        test_backpressure();
        test_reset_mid_wait();
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
